l1_cache: RTL and testbench

Blocking, direct-mapped, write-through, no-write-allocate L1 cache between the CPU and the L2 cache. It serves CPU word reads and writes. On a read miss it fills a whole line from L2, one word per L2 handshake. Every write is forwarded to L2. Its downstream port drives the L2 l1_cache_* interface one-to-one.

---
 rtl/l1_cache.sv | 209 ++++++++++++++++++++
 tb/tb_l1_cache.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_cache.sv
// Blocking direct-mapped write-through L1 data cache.
// Read misses fill a whole line from L2, word 0 upward.
module l1_cache #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CACHE_SIZE = 256,
  parameter int BLOCK_SIZE = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_data_in,
  input  logic                  cpu_read,
  input  logic                  cpu_write,
  output logic [DATA_WIDTH-1:0] cpu_data_out,
  output logic                  cpu_ready,
  output logic [ADDR_WIDTH-1:0] l2_addr,
  output logic [DATA_WIDTH-1:0] l2_data_out,
  input  logic [DATA_WIDTH-1:0] l2_data_in,
  output logic                  l2_read,
  output logic                  l2_write,
  input  logic                  l2_ready,
  output logic [15:0]           read_hits,
  output logic [15:0]           read_misses
);

  localparam int WORDS = BLOCK_SIZE / 4;
  localparam int LINES = CACHE_SIZE / BLOCK_SIZE;
  localparam int WS_W  = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int OFF_W = $clog2(BLOCK_SIZE);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - OFF_W;
  localparam int TAG_L = OFF_W + IDX_W;

  typedef enum logic [1:0] {
    IDLE, FILL, WRITE_THRU, DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [WS_W-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   cap_q, cap_d;
  logic [LINES-1:0]        valid_q, valid_d;
  logic                    cpu_ready_q, cpu_ready_d;
  logic [DATA_WIDTH-1:0]   cpu_data_out_q, cpu_data_out_d;
  logic [ADDR_WIDTH-1:0]   l2_addr_q, l2_addr_d;
  logic [DATA_WIDTH-1:0]   l2_data_out_q, l2_data_out_d;
  logic                    l2_read_q, l2_read_d;
  logic                    l2_write_q, l2_write_d;
  logic [15:0]             read_hits_q, read_hits_d;
  logic [15:0]             read_misses_q, read_misses_d;

  logic [DATA_WIDTH-1:0]   mem_q [LINES*WORDS];
  logic [TAG_W-1:0]        tag_q [LINES];

  logic                    mem_we;
  logic [IDX_W+WS_W-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    tag_we;

  logic [WS_W-1:0]         req_ws, lat_ws;
  logic [IDX_W-1:0]        req_idx, lat_idx;
  logic [TAG_W-1:0]        req_tag, lat_tag;
  logic                    hit;
  logic [DATA_WIDTH-1:0]   hit_word;
  logic                    unused_addr_bits;

  assign req_ws  = cpu_addr[OFF_W-1:2];
  assign req_idx = cpu_addr[TAG_L-1:OFF_W];
  assign req_tag = cpu_addr[ADDR_WIDTH-1:TAG_L];
  assign lat_ws  = addr_q[OFF_W-1:2];
  assign lat_idx = addr_q[TAG_L-1:OFF_W];
  assign lat_tag = addr_q[ADDR_WIDTH-1:TAG_L];

  assign unused_addr_bits = ^{cpu_addr[1:0], addr_q[1:0]};

  assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign hit_word = mem_q[{req_idx, req_ws}];

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    cnt_d          = cnt_q;
    cap_d          = cap_q;
    valid_d        = valid_q;
    cpu_ready_d    = 1'b0;
    cpu_data_out_d = cpu_data_out_q;
    l2_addr_d      = l2_addr_q;
    l2_data_out_d  = l2_data_out_q;
    l2_read_d      = l2_read_q;
    l2_write_d     = l2_write_q;
    read_hits_d    = read_hits_q;
    read_misses_d  = read_misses_q;
    mem_we         = 1'b0;
    mem_waddr      = {req_idx, req_ws};
    mem_wdata      = cpu_data_in;
    tag_we         = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_write) begin
          addr_d        = cpu_addr;
          mem_we        = hit;
          l2_write_d    = 1'b1;
          l2_addr_d     = {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
          l2_data_out_d = cpu_data_in;
          state_d       = WRITE_THRU;
        end else if (cpu_read) begin
          addr_d = cpu_addr;
          if (hit) begin
            cpu_data_out_d = hit_word;
            cpu_ready_d    = 1'b1;
            if (read_hits_q != '1)
              read_hits_d = read_hits_q + 16'd1;
            state_d = DONE;
          end else begin
            if (read_misses_q != '1)
              read_misses_d = read_misses_q + 16'd1;
            cnt_d     = '0;
            l2_read_d = 1'b1;
            l2_addr_d = {cpu_addr[ADDR_WIDTH-1:OFF_W],
                         {WS_W{1'b0}}, 2'b00};
            state_d   = FILL;
          end
        end
      end
      FILL: begin
        if (l2_ready) begin
          mem_we    = 1'b1;
          mem_waddr = {lat_idx, cnt_q};
          mem_wdata = l2_data_in;
          if (cnt_q == lat_ws)
            cap_d = l2_data_in;
          if (cnt_q == WS_W'(WORDS-1)) begin
            l2_read_d        = 1'b0;
            valid_d[lat_idx] = 1'b1;
            tag_we           = 1'b1;
            cpu_data_out_d   = (cnt_q == lat_ws) ?
                               l2_data_in : cap_q;
            cpu_ready_d      = 1'b1;
            state_d          = DONE;
          end else begin
            cnt_d     = cnt_q + WS_W'(1);
            l2_addr_d = {addr_q[ADDR_WIDTH-1:OFF_W],
                         cnt_q + WS_W'(1), 2'b00};
          end
        end
      end
      WRITE_THRU: begin
        if (l2_ready) begin
          l2_write_d  = 1'b0;
          cpu_ready_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      cnt_q          <= '0;
      cap_q          <= '0;
      valid_q        <= '0;
      cpu_ready_q    <= 1'b0;
      cpu_data_out_q <= '0;
      l2_addr_q      <= '0;
      l2_data_out_q  <= '0;
      l2_read_q      <= 1'b0;
      l2_write_q     <= 1'b0;
      read_hits_q    <= '0;
      read_misses_q  <= '0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      cnt_q          <= cnt_d;
      cap_q          <= cap_d;
      valid_q        <= valid_d;
      cpu_ready_q    <= cpu_ready_d;
      cpu_data_out_q <= cpu_data_out_d;
      l2_addr_q      <= l2_addr_d;
      l2_data_out_q  <= l2_data_out_d;
      l2_read_q      <= l2_read_d;
      l2_write_q     <= l2_write_d;
      read_hits_q    <= read_hits_d;
      read_misses_q  <= read_misses_d;
    end
  end

  // Line storage needs no reset: valid_q gates every use.
  always_ff @(posedge clk) begin
    if (mem_we)
      mem_q[mem_waddr] <= mem_wdata;
    if (tag_we)
      tag_q[lat_idx] <= lat_tag;
  end

  assign cpu_ready    = cpu_ready_q;
  assign cpu_data_out = cpu_data_out_q;
  assign l2_addr      = l2_addr_q;
  assign l2_data_out  = l2_data_out_q;
  assign l2_read      = l2_read_q;
  assign l2_write     = l2_write_q;
  assign read_hits    = read_hits_q;
  assign read_misses  = read_misses_q;

endmodule

// File: tb/tb_l1_cache.sv
// Bench for l1_cache: directed scenarios plus random traffic
// checked against a line-level cache and L2 memory model.
module tb_l1_cache;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_data_in = '0;
  logic        cpu_read = 1'b0;
  logic        cpu_write = 1'b0;
  logic [31:0] cpu_data_out;
  logic        cpu_ready;
  logic [31:0] l2_addr;
  logic [31:0] l2_data_out;
  logic [31:0] l2_data_in = '0;
  logic        l2_read;
  logic        l2_write;
  logic        l2_ready = 1'b0;
  logic [15:0] read_hits;
  logic [15:0] read_misses;

  always #5 clk = ~clk;

  l1_cache dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in),
    .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_data_out(cpu_data_out), .cpu_ready(cpu_ready),
    .l2_addr(l2_addr), .l2_data_out(l2_data_out),
    .l2_data_in(l2_data_in), .l2_read(l2_read),
    .l2_write(l2_write), .l2_ready(l2_ready),
    .read_hits(read_hits), .read_misses(read_misses)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t act_q[$];
  txn_t exp_q[$];

  logic [31:0] l2mem [logic [31:0]];

  function automatic logic [31:0] l2_peek(logic [31:0] a);
    if (l2mem.exists(a)) return l2mem[a];
    return {~a[15:0], a[15:0]};
  endfunction

  // L2 responder
  int wait_cnt = -1;
  bit rand_delay = 0;
  bit spur_en = 0;

  always @(negedge clk) begin
    l2_ready = 1'b0;
    if (!rst_n) begin
      wait_cnt = -1;
    end else if (l2_read || l2_write) begin
      if (wait_cnt < 0)
        wait_cnt = rand_delay ? int'($urandom_range(3, 0)) : 2;
      if (wait_cnt == 0) begin
        if (l2_write) begin
          l2mem[l2_addr] = l2_data_out;
          act_q.push_back(txn_t'{1'b1, l2_addr, l2_data_out});
        end else begin
          l2_data_in = l2_peek(l2_addr);
          act_q.push_back(txn_t'{1'b0, l2_addr, l2_data_in});
        end
        l2_ready = 1'b1;
        wait_cnt = -1;
      end else begin
        wait_cnt--;
      end
    end else if (spur_en && $urandom_range(7, 0) == 0) begin
      l2_ready   = 1'b1;
      l2_data_in = $urandom;
    end
  end

  // Behavioural cache model
  bit          mvalid [16];
  logic [23:0] mtag   [16];
  logic [31:0] mdata  [16][4];
  int          m_hits = 0;
  int          m_misses = 0;
  bit          pending = 0;
  bit          exp_rd = 0;
  logic [31:0] exp_data = '0;

  task automatic model_req(bit wr, logic [31:0] a,
                           logic [31:0] d, output bit hit);
    int line, idx, ws;
    logic [23:0] tg;
    logic [31:0] base;
    line = int'(a / 16);
    idx  = line % 16;
    ws   = int'((a % 16) / 4);
    tg   = 24'(line / 16);
    hit  = mvalid[idx] && (mtag[idx] == tg);
    exp_q.delete();
    exp_rd = !wr;
    if (wr) begin
      exp_q.push_back(txn_t'{1'b1, a & 32'hFFFF_FFFC, d});
      if (hit) mdata[idx][ws] = d;
    end else if (hit) begin
      exp_data = mdata[idx][ws];
      if (m_hits < 65535) m_hits++;
    end else begin
      if (m_misses < 65535) m_misses++;
      for (int i = 0; i < 4; i++) begin
        base = (a & 32'hFFFF_FFF0) + 32'(4 * i);
        mdata[idx][i] = l2_peek(base);
        exp_q.push_back(txn_t'{1'b0, base, mdata[idx][i]});
      end
      mvalid[idx] = 1'b1;
      mtag[idx]   = tg;
      exp_data    = mdata[idx][ws];
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
    m_hits   = 0;
    m_misses = 0;
    pending  = 0;
  endtask

  // Per-cycle output compare
  always @(negedge clk) begin
    if (rst_n) begin
      chk("l2_strobe_excl", {31'b0, l2_read & l2_write}, 32'd0);
      if (cpu_ready) begin
        if (!pending) begin
          chk("unexpected_ready", {31'b0, cpu_ready}, 32'd0);
        end else begin
          if (exp_rd) chk("rdata", cpu_data_out, exp_data);
          chk("read_hits", {16'b0, read_hits}, 32'(m_hits));
          chk("read_misses", {16'b0, read_misses},
              32'(m_misses));
          pending = 0;
        end
      end
    end
  end

  task automatic do_req(bit wr, logic [31:0] a, logic [31:0] d,
                        output int lat, output logic [31:0] rdata);
    bit hit;
    model_req(wr, a, d, hit);
    act_q.delete();
    pending     = 1;
    cpu_addr    = a;
    cpu_data_in = d;
    cpu_write   = wr;
    cpu_read    = !wr;
    @(posedge clk);
    @(negedge clk);
    cpu_read    = 1'b0;
    cpu_write   = 1'b0;
    cpu_addr    = $urandom;
    cpu_data_in = $urandom;
    lat = 1;
    while (!cpu_ready && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!cpu_ready)
      chk("ready_timeout", 32'(lat), 32'd0);
    rdata = cpu_data_out;
    if (!wr && hit) chk("hit_latency", 32'(lat), 32'd1);
    chk("txn_count", 32'(act_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      chk("txn_kind", {31'b0, act_q[i].wr}, {31'b0, exp_q[i].wr});
      chk("txn_addr", act_q[i].addr, exp_q[i].addr);
      chk("txn_data", act_q[i].data, exp_q[i].data);
    end
    @(negedge clk);
    chk("ready_one_cycle", {31'b0, cpu_ready}, 32'd0);
  endtask

  task automatic chk_zero_outputs(string tag);
    chk({tag, "_cpu_ready"}, {31'b0, cpu_ready}, 32'd0);
    chk({tag, "_cpu_data_out"}, cpu_data_out, 32'd0);
    chk({tag, "_l2_addr"}, l2_addr, 32'd0);
    chk({tag, "_l2_data_out"}, l2_data_out, 32'd0);
    chk({tag, "_l2_read"}, {31'b0, l2_read}, 32'd0);
    chk({tag, "_l2_write"}, {31'b0, l2_write}, 32'd0);
    chk({tag, "_read_hits"}, {16'b0, read_hits}, 32'd0);
    chk({tag, "_read_misses"}, {16'b0, read_misses}, 32'd0);
  endtask

  initial begin
    int lat;
    int waited;
    logic [31:0] rd;
    logic [31:0] a;
    for (int i = 0; i < 4; i++)
      l2mem[32'h100 + 32'(4 * i)] = 32'hA0 + 32'(i);
    model_reset();
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Cold read miss fills the line in order
    do_req(0, 32'h104, 0, lat, rd);
    chk("t1_data", rd, 32'hA1);
    chk("t1_misses", {16'b0, read_misses}, 32'd1);
    chk("t1_nreads", 32'(act_q.size()), 32'd4);
    for (int i = 0; i < act_q.size() && i < 4; i++)
      chk("t1_addr", act_q[i].addr, 32'h100 + 32'(4 * i));

    do_req(0, 32'h108, 0, lat, rd);
    chk("t2_latency", 32'(lat), 32'd1);
    chk("t2_data", rd, 32'hA2);
    chk("t2_no_l2", 32'(act_q.size()), 32'd0);
    chk("t2_hits", {16'b0, read_hits}, 32'd1);

    do_req(1, 32'h104, 32'hDEADBEEF, lat, rd);
    chk("t3_nwrites", 32'(act_q.size()), 32'd1);
    if (act_q.size() > 0) begin
      chk("t3_wr", {31'b0, act_q[0].wr}, 32'd1);
      chk("t3_addr", act_q[0].addr, 32'h104);
      chk("t3_data", act_q[0].data, 32'hDEADBEEF);
    end
    do_req(0, 32'h104, 0, lat, rd);
    chk("t3_read_back", rd, 32'hDEADBEEF);
    chk("t3_hit_lat", 32'(lat), 32'd1);

    // Write miss must not allocate
    do_req(1, 32'h2000, 32'h12345678, lat, rd);
    chk("t4_ntxn", 32'(act_q.size()), 32'd1);
    do_req(0, 32'h2000, 0, lat, rd);
    chk("t4_nreads", 32'(act_q.size()), 32'd4);
    if (act_q.size() > 0)
      chk("t4_first_addr", act_q[0].addr, 32'h2000);
    chk("t4_data", rd, 32'h12345678);

    // Conflicting lines on the same index
    do_req(0, 32'h204, 0, lat, rd);
    if (act_q.size() > 0)
      chk("t5_first_addr", act_q[0].addr, 32'h200);
    do_req(0, 32'h104, 0, lat, rd);
    chk("t5_nreads", 32'(act_q.size()), 32'd4);
    chk("t5_data", rd, 32'hDEADBEEF);
    chk("t5_misses", {16'b0, read_misses}, 32'd4);

    // Reset in the middle of a fill
    do_req(0, 32'h304, 0, lat, rd);
    act_q.delete();
    pending  = 0;
    cpu_addr = 32'h104;
    cpu_read = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cpu_read = 1'b0;
    waited = 0;
    while (act_q.size() < 2 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    chk("t6_partial_fill", 32'(act_q.size()), 32'd2);
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("t6_reset");
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_req(0, 32'h104, 0, lat, rd);
    chk("t6_refill", 32'(act_q.size()), 32'd4);
    chk("t6_data", rd, 32'hDEADBEEF);
    chk("t6_misses", {16'b0, read_misses}, 32'd1);

    // Random traffic
    rand_delay = 1;
    spur_en    = 1;
    for (int n = 0; n < 400; n++) begin
      a = (32'($urandom_range(3, 0)) << 8) |
          (32'($urandom_range(255, 0)) & 32'hFC);
      do_req($urandom_range(2, 0) == 0, a, $urandom, lat, rd);
    end
    spur_en = 0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
